// File: rtl/id_ex_pipe_reg_if.sv
// Decode->Execute bundle: D-side instruction fields, flush/stall controls and the registered
// E-side copies plus the bubble counter.
interface id_ex_pipe_reg_if #(
   parameter int unsigned DW    = 32,
   parameter int unsigned AW    = 5,
   parameter int unsigned CNT_W = 16
);
   logic          FlushE;
   logic          StallE;
   logic          ValidD;
   logic          RegWriteD;
   logic          MemToRegD;
   logic          MemWriteD;
   logic          ALUSrcD;
   logic          RegDstD;
   logic [3:0]    ALUControlD;
   logic [DW-1:0] RD1D;
   logic [DW-1:0] RD2D;
   logic [AW-1:0] RsD;
   logic [AW-1:0] RtD;
   logic [AW-1:0] RdD;
   logic [DW-1:0] SignImmD;
   logic [DW-1:0] PCPlus4D;

   logic             ValidE;
   logic             RegWriteE;
   logic             MemToRegE;
   logic             MemWriteE;
   logic             ALUSrcE;
   logic             RegDstE;
   logic [3:0]       ALUControlE;
   logic [DW-1:0]    RD1E;
   logic [DW-1:0]    RD2E;
   logic [AW-1:0]    RsE;
   logic [AW-1:0]    RtE;
   logic [AW-1:0]    RdE;
   logic [DW-1:0]    SignImmE;
   logic [DW-1:0]    PCPlus4E;
   logic [CNT_W-1:0] BubbleCntE;

   modport master (
      output FlushE, StallE, ValidD, RegWriteD, MemToRegD, MemWriteD, ALUSrcD, RegDstD,
             ALUControlD, RD1D, RD2D, RsD, RtD, RdD, SignImmD, PCPlus4D,
      input  ValidE, RegWriteE, MemToRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE,
             RD1E, RD2E, RsE, RtE, RdE, SignImmE, PCPlus4E, BubbleCntE
   );

   modport slave (
      input  FlushE, StallE, ValidD, RegWriteD, MemToRegD, MemWriteD, ALUSrcD, RegDstD,
             ALUControlD, RD1D, RD2D, RsD, RtD, RdD, SignImmD, PCPlus4D,
      output ValidE, RegWriteE, MemToRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE,
             RD1E, RD2E, RsE, RtE, RdE, SignImmE, PCPlus4E, BubbleCntE
   );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// Decode->Execute pipeline register with flush (bubble insert), stall (hold) and a saturating
// count of bubbles entering Execute.
module id_ex_pipe_reg #(
   parameter int unsigned DW    = 32,
   parameter int unsigned AW    = 5,
   parameter int unsigned CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   id_ex_pipe_reg_if.slave   bus
);
   typedef struct packed {
      logic          valid;
      logic          reg_write;
      logic          mem_to_reg;
      logic          mem_write;
      logic          alu_src;
      logic          reg_dst;
      logic [3:0]    alu_control;
      logic [DW-1:0] rd1;
      logic [DW-1:0] rd2;
      logic [AW-1:0] rs;
      logic [AW-1:0] rt;
      logic [AW-1:0] rd;
      logic [DW-1:0] sign_imm;
      logic [DW-1:0] pc_plus4;
   } e_t;

   e_t               e_d, e_q;
   logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
   logic             bubble_in;

   always_comb begin
      e_d          = e_q;
      bubble_cnt_d = bubble_cnt_q;
      bubble_in    = bus.FlushE | (~bus.StallE & ~bus.ValidD);

      if (bus.FlushE) begin
         e_d = '0;
      end else if (!bus.StallE) begin
         e_d.valid    = bus.ValidD;
         e_d.rd1      = bus.RD1D;
         e_d.rd2      = bus.RD2D;
         e_d.rs       = bus.RsD;
         e_d.rt       = bus.RtD;
         e_d.rd       = bus.RdD;
         e_d.sign_imm = bus.SignImmD;
         e_d.pc_plus4 = bus.PCPlus4D;
         // Control is gated by ValidD so a bubble can never write regfile or memory.
         e_d.reg_write   = bus.ValidD & bus.RegWriteD;
         e_d.mem_to_reg  = bus.ValidD & bus.MemToRegD;
         e_d.mem_write   = bus.ValidD & bus.MemWriteD;
         e_d.alu_src     = bus.ValidD & bus.ALUSrcD;
         e_d.reg_dst     = bus.ValidD & bus.RegDstD;
         e_d.alu_control = bus.ValidD ? bus.ALUControlD : 4'b0000;
      end

      if (bubble_in && (bubble_cnt_q != {CNT_W{1'b1}})) begin
         bubble_cnt_d = bubble_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_q          <= '0;
         bubble_cnt_q <= '0;
      end else begin
         e_q          <= e_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign bus.ValidE      = e_q.valid;
   assign bus.RegWriteE   = e_q.reg_write;
   assign bus.MemToRegE   = e_q.mem_to_reg;
   assign bus.MemWriteE   = e_q.mem_write;
   assign bus.ALUSrcE     = e_q.alu_src;
   assign bus.RegDstE     = e_q.reg_dst;
   assign bus.ALUControlE = e_q.alu_control;
   assign bus.RD1E        = e_q.rd1;
   assign bus.RD2E        = e_q.rd2;
   assign bus.RsE         = e_q.rs;
   assign bus.RtE         = e_q.rt;
   assign bus.RdE         = e_q.rd;
   assign bus.SignImmE    = e_q.sign_imm;
   assign bus.PCPlus4E    = e_q.pc_plus4;
   assign bus.BubbleCntE  = bubble_cnt_q;
endmodule
